dds_wave_ctrl: RTL and testbench

- Single-clock sequencer for the DDS waveform RAM: an 8-bit wide, 16K-deep simple dual-port RAM with a registered output.
- Owns both RAM ports: streams host samples into one of four 4096-entry waveform segments (LOAD), or runs a 32-bit phase accumulator that reads the selected segment for playback (RUN).
- Sits between the host/config logic and the DAC output path; guarantees load and playback never overlap.

---
 rtl/dds_wave_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_dds_wave_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_ctrl.sv
// DDS waveform RAM sequencer: streams host samples into one of four segments, or plays a
// segment back through a phase accumulator. Optional amplitude scaling: DDS_WAVE_CTRL_AMP_SCALE_EN.
module dds_wave_ctrl #(
    parameter int ACC_W  = 32,
    parameter int SEG_AW = 12,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DDS_WAVE_CTRL_AMP_SCALE_EN
    input  logic [7:0]        amp,
`endif
    input  logic              run_en,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [ACC_W-1:0]  phase_ofs,
    input  logic [1:0]        wave_sel,
    input  logic              cfg_upd,
    input  logic              load_start,
    input  logic [1:0]        load_seg,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    output logic [7:0]        ram_wr_data,
    output logic [SEG_AW+1:0] ram_wr_addr,
    output logic              ram_wr_en,
    output logic [SEG_AW+1:0] ram_rd_addr,
    input  logic [7:0]        ram_rd_data,
    output logic [7:0]        dout,
    output logic              dout_valid
);
    localparam int AW = SEG_AW + 2;
`ifdef DDS_WAVE_CTRL_AMP_SCALE_EN
    localparam int DLAT = RD_LAT + 1;
`else
    localparam int DLAT = RD_LAT;
`endif
    localparam int DCW = $clog2(DLAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, LOAD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   freq_sh_q, ofs_sh_q;
    logic [1:0]         sel_sh_q;
    logic [1:0]         seg_q, seg_d;
    logic [SEG_AW-1:0]  cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [DCW-1:0]     dcnt_q, dcnt_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               issue_q, issue_d;
    logic               done_q, done_d;
    logic [RD_LAT-1:0]  vld_q;
    logic [RD_LAT:0]    vld_pipe;
    logic               rd_vld;
    logic [7:0]         dout_q;

    // Shadow configuration; raw config inputs only ever reach the datapath through here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_sh_q <= '0;
            ofs_sh_q  <= '0;
            sel_sh_q  <= '0;
        end else if (cfg_upd) begin
            freq_sh_q <= freq_word;
            ofs_sh_q  <= phase_ofs;
            sel_sh_q  <= wave_sel;
        end
    end

    assign ld_ready    = (state_q == LOAD);
    assign ram_wr_en   = ld_ready & ld_valid;
    assign ram_wr_addr = {seg_q, cnt_q};
    assign ram_wr_data = ram_wr_en ? ld_data : '0;
    assign ram_rd_addr = rd_addr_q;
    assign ld_done     = done_q;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        seg_d     = seg_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        dcnt_d    = dcnt_q;
        rd_addr_d = rd_addr_q;
        issue_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    seg_d   = load_seg;
                    cnt_d   = '0;
                end else if (run_en) begin
                    state_d = RUN;
                    acc_d   = '0;
                end
            end
            RUN: begin
                // The exit cycle issues no read, so DRAIN covers exactly the in-flight reads.
                if (!run_en || load_start) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                    pend_d  = load_start;
                    if (load_start) seg_d = load_seg;
                end else begin
                    acc_d     = acc_q + freq_sh_q;
                    rd_addr_d = {sel_sh_q, SEG_AW'((acc_q + ofs_sh_q) >> (ACC_W - SEG_AW))};
                    issue_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == DCW'(DLAT - 1)) begin
                    state_d = pend_q ? LOAD : IDLE;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            seg_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            dcnt_q    <= '0;
            rd_addr_q <= '0;
            issue_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            dcnt_q    <= dcnt_d;
            rd_addr_q <= rd_addr_d;
            issue_q   <= issue_d;
            done_q    <= done_d;
        end
    end

    // issue_q marks the cycle a fresh address sits on ram_rd_addr; data lands RD_LAT later.
    assign vld_pipe = {vld_q, issue_q};
    assign rd_vld   = vld_pipe[RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_pipe[RD_LAT-1:0];
    end

`ifdef DDS_WAVE_CTRL_AMP_SCALE_EN
    logic [7:0]         amp_sh_q;
    logic signed [8:0]  smp_s;
    logic signed [17:0] prod;
    logic signed [9:0]  scl;
    logic [7:0]         scaled;
    logic               dval_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       amp_sh_q <= 8'hFF;
        else if (cfg_upd) amp_sh_q <= amp;
    end

    // Offset-binary sample re-centred around zero, scaled by amp/256, re-biased and clamped.
    always_comb begin
        smp_s = $signed({1'b0, ram_rd_data}) - 9'sd128;
        prod  = smp_s * $signed({1'b0, amp_sh_q});
        scl   = 10'(prod >>> 8) + 10'sd128;
        if (scl < 0)            scaled = 8'd0;
        else if (scl > 10'sd255) scaled = 8'hFF;
        else                    scaled = scl[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            dval_q <= 1'b0;
        end else begin
            dval_q <= rd_vld;
            if (rd_vld) dout_q <= scaled;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dval_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_vld) dout_q <= ram_rd_data;
    end

    assign dout       = rd_vld ? ram_rd_data : dout_q;
    assign dout_valid = rd_vld;
`endif

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Randomized bench for dds_wave_ctrl: owns a RAM model and a reference image of the RAM.
module tb_dds_wave_ctrl;
    localparam int RD_LAT = 2;
    localparam int NSEG   = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic [31:0] freq_word = '0;
    logic [31:0] phase_ofs = '0;
    logic [1:0]  wave_sel = '0;
    logic        cfg_upd = 1'b0;
    logic        load_start = 1'b0;
    logic [1:0]  load_seg = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready, ld_done, busy, ram_wr_en, dout_valid;
    logic [7:0]  ram_wr_data, dout;
    logic [13:0] ram_wr_addr, ram_rd_addr;
    logic [7:0]  rd_q;
    logic [13:0] ra_q;

    bit [7:0] ram     [16384];
    bit [7:0] mem_ref [16384];

    int checks = 0;
    int failures = 0;

    dds_wave_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .freq_word(freq_word),
        .phase_ofs(phase_ofs), .wave_sel(wave_sel), .cfg_upd(cfg_upd),
        .load_start(load_start), .load_seg(load_seg), .ld_data(ld_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy),
        .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(rd_q), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM: address register then output register.
    always @(posedge clk) begin
        if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
        ra_q <= ram_rd_addr;
        rd_q <= ram[ra_q];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode 0: ld_valid always, 1: alternating starting low, 2: random gaps.
    task automatic do_load(input logic [1:0] seg, input int mode, input bit ramp,
                           input bit started, input int lim);
        int idx, cyc;
        logic [7:0]  s;
        logic [13:0] wa;
        idx = 0;
        cyc = 0;
        if (!started) begin
            @(negedge clk);
            load_start = 1'b1;
            load_seg   = seg;
            run_en     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 load_start = 1'b0;
            run_en = 1'b0;
        end
        while (idx < lim && cyc < 3 * NSEG + 16) begin
            @(negedge clk);
            s = ramp ? idx[7:0] : 8'($urandom);
            case (mode)
                0:       ld_valid = 1'b1;
                1:       ld_valid = cyc[0];
                default: ld_valid = 1'($urandom_range(0, 1));
            endcase
            ld_data    = s;
            load_start = 1'($urandom_range(0, 1));
            load_seg   = 2'($urandom);
            run_en     = 1'($urandom_range(0, 1));
            #1;
            chk("ld_ready", ld_ready, 1);
            chk("ld_busy", busy, 1);
            chk("ld_wr_en", ram_wr_en, ld_valid);
            if (ld_valid) begin
                wa = {seg, idx[11:0]};
                chk("ld_addr", ram_wr_addr, wa);
                chk("ld_data", ram_wr_data, s);
                mem_ref[wa] = s;
                idx++;
            end
            cyc++;
        end
        chk("ld_count", idx, lim);
        if (mode == 0) chk("ld_cycles", cyc, lim);
        if (mode == 1) chk("ld_cycles", cyc, 2 * lim);
        @(posedge clk);
        #1 load_start = 1'b0;
        run_en = 1'b0;
        if (lim < NSEG) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_ready", ld_ready, 0);
            chk("rst_wr_en", ram_wr_en, 0);
            chk("rst_dval", dout_valid, 0);
            ld_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            ld_valid = 1'b0;
            @(negedge clk);
            chk("ld_done", ld_done, 1);
            chk("ld_done_busy", busy, 0);
            chk("ld_done_ready", ld_ready, 0);
            chk("ld_done_wr_en", ram_wr_en, 0);
            @(negedge clk);
            chk("ld_done_pulse", ld_done, 0);
        end
    endtask

    // Play n reads, then stop by dropping run_en or by a load request.
    task automatic play(input logic [1:0] sel, input logic [31:0] fw, input logic [31:0] po,
                        input int n, input bit by_load, input logic [1:0] lseg);
        logic [13:0] addr[$];
        logic [31:0] ph;
        bit          v;
        int          ai;
        for (int k = 0; k < n; k++) begin
            ph = fw * 32'(k) + po;
            addr.push_back({sel, ph[31:20]});
        end
        @(negedge clk);
        freq_word = fw;
        phase_ofs = po;
        wave_sel  = sel;
        cfg_upd   = 1'b1;
        @(negedge clk);
        cfg_upd   = 1'b0;
        freq_word = $urandom;
        phase_ofs = $urandom;
        wave_sel  = 2'($urandom);
        run_en    = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= n + RD_LAT + 1; j++) begin
            @(posedge clk);
            if (j == n) begin
                #1;
                if (by_load) begin
                    load_start = 1'b1;
                    load_seg   = lseg;
                end else begin
                    run_en = 1'b0;
                end
            end
            if (j == n + 1) begin
                #1 load_start = 1'b0;
                run_en = 1'b0;
            end
            @(negedge clk);
            ai = (j <= n) ? j - 1 : n - 1;
            chk("rd_addr", ram_rd_addr, addr[ai]);
            v = (j >= 1 + RD_LAT) && (j <= n + RD_LAT);
            chk("dout_valid", dout_valid, v);
            if (v) chk("dout", dout, mem_ref[addr[j-1-RD_LAT]]);
            else if (j > n + RD_LAT) chk("dout_hold", dout, mem_ref[addr[n-1]]);
            chk("play_wr_en", ram_wr_en, 0);
            if (j <= n + RD_LAT) begin
                chk("play_busy", busy, 1);
                chk("play_ready", ld_ready, 0);
            end else begin
                chk("end_busy", busy, by_load);
                chk("end_ready", ld_ready, by_load);
            end
        end
    endtask

    initial begin
        logic [1:0]  rs;
        logic [31:0] rf;
        int          rn;
        bit          rb;
        rst_n  = 1'b0;
        run_en = 1'b1;
        ld_data = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", busy, 0);
        chk("rst_dval0", dout_valid, 0);
        chk("rst_dout0", dout, 0);
        chk("rst_ready0", ld_ready, 0);
        chk("rst_done0", ld_done, 0);
        chk("rst_wren0", ram_wr_en, 0);
        chk("rst_rdaddr0", ram_rd_addr, 0);
        chk("rst_wraddr0", ram_wr_addr, 0);
        chk("rst_wrdata0", ram_wr_data, 0);
        run_en = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        do_load(2'd1, 0, 1'b1, 1'b0, NSEG);
        do_load(2'd1, 1, 1'b1, 1'b0, NSEG);
        do_load(2'd0, 2, 1'b0, 1'b0, NSEG);
        do_load(2'd2, 0, 1'b0, 1'b0, NSEG);
        do_load(2'd3, 0, 1'b0, 1'b0, NSEG);

        play(2'd1, 32'h0010_0000, 32'h0, 20, 1'b0, 2'd0);
        play(2'd1, 32'h0010_0000, 32'hFFF0_0000, 4, 1'b0, 2'd0);
        play(2'd2, 32'h0, $urandom, 6, 1'b0, 2'd0);
        play(2'd3, $urandom, $urandom, 10, 1'b1, 2'd0);
        do_load(2'd0, 0, 1'b0, 1'b1, NSEG);
        play(2'd0, 32'h0030_0000, $urandom, 12, 1'b0, 2'd0);

        do_load(2'd2, 0, 1'b0, 1'b0, 100);
        play(2'd2, 32'h0010_0000, 32'h0, 110, 1'b0, 2'd0);

        for (int it = 0; it < 8; it++) begin
            rs = 2'($urandom);
            case ($urandom_range(0, 2))
                0:       rf = 32'h0;
                1:       rf = 32'($urandom_range(1, 40)) << 20;
                default: rf = $urandom;
            endcase
            rn = $urandom_range(1, 25);
            rb = ($urandom_range(0, 3) == 0);
            play(rs, rf, $urandom, rn, rb, 2'($urandom));
            if (rb) do_load(2'd0, 0, 1'b0, 1'b1, NSEG);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
